mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Writeback stage of the 5-stage RISC-V pipeline, directly downstream of the MEM stage. Holds the MEM/WB pipeline register, aligns it with the registered data-memory read port (one-cycle read latency), extracts load data, and drives the register-file write port and EX-stage forwarding path. A hold buffer preserves load data across WB stalls, and an instruction-retired counter is maintained here.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- mem_valid  in  1  MEM stage holds a valid instruction this cycle
- ALU_result  in  32  ALU result / effective address from MEM stage
- read_data  in  32  data-memory read port (registered in memory, valid the cycle after address presented)
- rd  in  5  destination register
- reg_w_ctrl_in  in  1  instruction writes rd
- MemToReg  in  1  1 = load, write memory data; 0 = write ALU_result
- funct3  in  3  load size/sign (used only with WB_SUBWORD_LOAD_EN)
- wb_stall  in  1  hold WB contents, suppress RF write
- wb_flush  in  1  invalidate WB contents
- mem_wb_ready  out  1  = !wb_stall; MEM stage must hold when 0
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- fwd_valid  out  1  forwarding source valid (independent of stall)
- fwd_rd  out  5  forwarding destination
- fwd_data  out  32  forwarding data (= rf_wdata)
- instret  out  CNT_W  retired-instruction count

## Operation
- Pipeline register fields: valid, ALU_result, rd, reg_w, MemToReg, funct3, addr_lo (=ALU_result[1:0]).
- Capture priority at each rising edge: reset > wb_flush (valid<=0, data fields don't-care) > !wb_stall (load all fields, valid<=mem_valid) > hold.
- Load-data FSM, states EMPTY, FRESH, HELD:
  - EMPTY: valid=0. FRESH when a valid instruction is captured.
  - FRESH: load data taken live from read_data. If wb_stall & !wb_flush: latch read_data into hold_buf, go HELD. If advancing: FRESH if new mem_valid, else EMPTY.
  - HELD: load data taken from hold_buf. Stays HELD while stalled; on advance behaves as FRESH.
  - wb_flush from any state -> EMPTY.
- HELD entered for non-loads too (harmless); select uses MemToReg.
- Raw data = MemToReg ? (HELD ? hold_buf : read_data) : ALU_result; loads pass through extraction.
- rf_we = valid & reg_w & (rd != 0) & !wb_stall. rf_waddr = rd, rf_wdata = selected data whenever valid, else 0.
- fwd_valid = valid & reg_w & (rd != 0), also during stall; fwd_rd/fwd_data mirror rf_waddr/rf_wdata.
- instret increments by 1 on each edge where valid & !wb_stall & !wb_flush; rd=x0 and non-writing instructions count. Wraps all-ones -> 0.

## Timing
- Reset: valid=0, state EMPTY, hold_buf=0, instret=0; rf_we=0, rf_waddr=0, rf_wdata=0, fwd_valid=0, fwd_rd=0, fwd_data=0. mem_wb_ready follows wb_stall combinationally, even in reset.
- Reset mid-stall discards held load data; no RF write occurs.
- Latency: instruction captured at edge N writes RF at edge N+1 (rf_we high during cycle N..N+1); read_data from memory is valid in the same cycle, no extra bubble.
- All outputs except mem_wb_ready are functions of registered state plus read_data; no combinational path from mem_valid/ALU_result/rd to outputs.
- Stall of any length: outputs stable, rf_we=0, data unchanged even if read_data changes after first stall cycle.
- Simultaneous wb_stall and wb_flush: flush wins, state EMPTY, instret unchanged.

## Configuration
- WB_SUBWORD_LOAD_EN defined: funct3 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Byte select addr_lo[1:0]; halfword select addr_lo[1] (addr_lo[0] ignored); lb/lh sign-extend, lbu/lhu zero-extend; other funct3 treated as lw.
- Undefined: raw 32-bit word written for all loads; funct3 and addr_lo unused.

## Test plan
- Reset then ALU op ALU_result=0x0000_1234, rd=5, reg_w=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; instret=1 after edge.
- Load rd=7, read_data=0xDEAD_BEEF next cycle -> rf_wdata=0xDEADBEEF; with macro, funct3=000, addr_lo=3 -> 0xFFFF_FFDE; funct3=101, addr_lo=2 -> 0x0000_DEAD.
- Load then wb_stall for 3 cycles while read_data changes to 0x0 -> rf_we=0 during stall, fwd_data=0xDEADBEEF throughout; on release rf_we=1, rf_wdata=0xDEADBEEF.
- Write to rd=0 -> rf_we=0, fwd_valid=0, instret still increments.
- wb_stall and wb_flush together on valid load -> next cycle fwd_valid=0, rf_we=0, instret unchanged; reset low mid-stall -> all outputs 0.
- Preload instret near all-ones (CNT_W=4, 15 retires) -> 16th retire yields instret=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: writeback stage of the 5-stage RISC-V pipeline.
//
// Holds the MEM/WB pipeline register and lines it up with the registered
// data-memory read port. Load data arrives on read_data one cycle after the
// address, which is the first cycle the instruction sits in WB. It is used
// live in that cycle and is copied into hold_buf if WB stalls. The stage
// drives the register-file write port and the EX forwarding path, and it
// counts retired instructions.
//
// Optional feature macro: WB_SUBWORD_LOAD_EN
//   defined   : lb/lh/lw/lbu/lhu extraction from the loaded word.
//   undefined : the raw 32-bit word is written for every load.
//
// Handshake: a MEM->WB transfer happens on a rising edge where mem_wb_ready
// is high. mem_valid qualifies the payload on that edge. When mem_wb_ready is
// low, the MEM stage must hold its instruction and WB keeps its contents.
// wb_flush overrides both and empties WB.

module mem_wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic [31:0]      ALU_result,
    input  logic [31:0]      read_data,
    input  logic [4:0]       rd,
    input  logic             reg_w_ctrl_in,
    input  logic             MemToReg,
    input  logic [2:0]       funct3,
    input  logic             wb_stall,
    input  logic             wb_flush,
    output logic             mem_wb_ready,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [31:0]      fwd_data,
    output logic [CNT_W-1:0] instret,
    output logic [1:0]       dbg_state
);

    // Load-data source tracking:
    //   EMPTY : no valid instruction in WB.
    //   FRESH : first WB cycle, so load data is read live from read_data.
    //   HELD  : stalled past the first cycle, so load data comes from hold_buf.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FRESH = 2'd1,
        ST_HELD  = 2'd2
    } ld_state_t;

    ld_state_t   state_q;
    logic [31:0] hold_buf_q;
    logic [31:0] alu_q;
    logic [4:0]  rd_q;
    logic        reg_w_q;
    logic        mem_to_reg_q;
    logic [CNT_W-1:0] instret_q;

    logic        valid;
    logic        advance;
    logic        writes_rd;
    logic [31:0] load_word;
    logic [31:0] load_ext;
    logic [31:0] sel_data;

    // WB accepts a new instruction whenever it is not stalled.
    assign mem_wb_ready = !wb_stall;
    assign advance      = !wb_stall && !wb_flush;
    assign valid        = (state_q != ST_EMPTY);

    // MEM/WB pipeline register. A flush leaves the data fields alone because
    // the cleared state already marks them as don't-care.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_q        <= 32'd0;
            rd_q         <= 5'd0;
            reg_w_q      <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else if (advance) begin
            alu_q        <= ALU_result;
            rd_q         <= rd;
            reg_w_q      <= reg_w_ctrl_in;
            mem_to_reg_q <= MemToReg;
        end
    end

`ifdef WB_SUBWORD_LOAD_EN
    logic [2:0] funct3_q;
    logic [1:0] addr_lo_q;
    logic [7:0] byte_sel;
    logic [15:0] half_sel;

    // Subword selection fields, captured alongside the main pipeline register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            funct3_q  <= 3'd0;
            addr_lo_q <= 2'd0;
        end else if (advance) begin
            funct3_q  <= funct3;
            addr_lo_q <= ALU_result[1:0];
        end
    end

    // Subword extraction: pick the byte/halfword, then sign- or zero-extend.
    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        load_ext = load_word;
        case (addr_lo_q)
            2'd0:    byte_sel = load_word[7:0];
            2'd1:    byte_sel = load_word[15:8];
            2'd2:    byte_sel = load_word[23:16];
            default: byte_sel = load_word[31:24];
        endcase
        half_sel = addr_lo_q[1] ? load_word[31:16] : load_word[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = load_word;
        endcase
    end
`else
    logic unused_funct3;

    // Without subword support the whole loaded word is written back.
    assign load_ext      = load_word;
    assign unused_funct3 = ^funct3;
`endif

    // Load-data FSM plus hold buffer. A flush always wins. On a stall in the
    // first cycle, the memory word is captured before read_data moves on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_EMPTY;
            hold_buf_q <= 32'd0;
        end else if (wb_flush) begin
            state_q <= ST_EMPTY;
        end else if (!wb_stall) begin
            state_q <= mem_valid ? ST_FRESH : ST_EMPTY;
        end else begin
            case (state_q)
                ST_FRESH: begin
                    hold_buf_q <= read_data;
                    state_q    <= ST_HELD;
                end
                ST_HELD:  state_q <= ST_HELD;
                default:  state_q <= ST_EMPTY;
            endcase
        end
    end

    // Retired-instruction counter. It counts every valid instruction that
    // leaves WB, including x0 targets and instructions that do not write rd.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_q <= '0;
        end else if (valid && advance) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Writeback data selection and output gating.
    assign load_word = (state_q == ST_HELD) ? hold_buf_q : read_data;
    assign sel_data  = mem_to_reg_q ? load_ext : alu_q;
    assign writes_rd = valid && reg_w_q && (rd_q != 5'd0);

    assign rf_we     = writes_rd && !wb_stall;
    assign rf_waddr  = valid ? rd_q : 5'd0;
    assign rf_wdata  = valid ? sel_data : 32'd0;
    assign fwd_valid = writes_rd;
    assign fwd_rd    = rf_waddr;
    assign fwd_data  = rf_wdata;
    assign instret   = instret_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized and directed bench for mem_wb_stage.
// The reference model treats WB as a one-instruction slot. An instruction's
// load word is whatever memory returned during its first WB cycle.
// Build with WB_SUBWORD_LOAD_EN to check subword extraction.

module tb_mem_wb_stage;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        mem_valid = 1'b0;
    logic [31:0] ALU_result = 32'd0;
    logic [31:0] read_data = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        reg_w_ctrl_in = 1'b0;
    logic        MemToReg = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic        wb_stall = 1'b0;
    logic        wb_flush = 1'b0;

    logic        mem_wb_ready, rf_we, fwd_valid;
    logic [4:0]  rf_waddr, fwd_rd;
    logic [31:0] rf_wdata, fwd_data, instret;
    logic [1:0]  dbg_state;

    logic        r4_ready, r4_we, r4_fv;
    logic [4:0]  r4_waddr, r4_frd;
    logic [31:0] r4_wdata, r4_fdata;
    logic [3:0]  instret4;
    logic [1:0]  r4_dbg;

    mem_wb_stage #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .ALU_result(ALU_result),
        .read_data(read_data), .rd(rd), .reg_w_ctrl_in(reg_w_ctrl_in),
        .MemToReg(MemToReg), .funct3(funct3), .wb_stall(wb_stall), .wb_flush(wb_flush),
        .mem_wb_ready(mem_wb_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .instret(instret), .dbg_state(dbg_state)
    );

    // Narrow-counter instance for checking the wrap
    mem_wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .ALU_result(ALU_result),
        .read_data(read_data), .rd(rd), .reg_w_ctrl_in(reg_w_ctrl_in),
        .MemToReg(MemToReg), .funct3(funct3), .wb_stall(wb_stall), .wb_flush(wb_flush),
        .mem_wb_ready(r4_ready), .rf_we(r4_we), .rf_waddr(r4_waddr),
        .rf_wdata(r4_wdata), .fwd_valid(r4_fv), .fwd_rd(r4_frd),
        .fwd_data(r4_fdata), .instret(instret4), .dbg_state(r4_dbg)
    );

    // ---------------- checking infrastructure ----------------
    int checks = 0;
    int failures = 0;
    logic [36:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid = 1'b0;
    logic [31:0] m_alu = 32'd0;
    logic [4:0]  m_rd = 5'd0;
    logic        m_regw = 1'b0;
    logic        m_load = 1'b0;
    logic [2:0]  m_f3 = 3'd0;
    logic        m_first = 1'b0;
    logic [31:0] m_word = 32'd0;
    logic [31:0] m_instret = 32'd0;

    function automatic logic [31:0] load_value(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] a);
`ifdef WB_SUBWORD_LOAD_EN
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * int'(a))) & 32'hFF;
        h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
`else
        if (f3 == 3'd7 && a == 2'd3) return w;
        return w;
`endif
    endfunction

    // Slot update at each edge: retire, then either empty, refill, or hold.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid = 1'b0;
            m_first = 1'b0;
            m_word = 32'd0;
            m_instret = 32'd0;
        end else begin
            if (m_valid && !wb_stall && !wb_flush) m_instret = m_instret + 1;
            if (wb_flush) begin
                m_valid = 1'b0;
            end else if (!wb_stall) begin
                m_valid = mem_valid;
                m_alu = ALU_result;
                m_rd = rd;
                m_regw = reg_w_ctrl_in;
                m_load = MemToReg;
                m_f3 = funct3;
                m_first = 1'b1;
            end else if (m_first) begin
                m_word = read_data;
                m_first = 1'b0;
            end
        end
    end

    // Compare process: every output against the model on every negedge.
    always @(negedge clk) begin
        logic [31:0] word;
        logic        wr;
        logic        exp_we;
        logic [36:0] got;
        word = m_load ? load_value(m_first ? read_data : m_word, m_f3, m_alu[1:0]) : m_alu;
        wr = m_valid && m_regw && (m_rd != 5'd0);
        exp_we = wr && !wb_stall;
        chk("mem_wb_ready", mem_wb_ready, !wb_stall);
        chk("rf_we", rf_we, exp_we);
        chk("rf_waddr", rf_waddr, m_valid ? m_rd : 5'd0);
        chk("rf_wdata", rf_wdata, m_valid ? word : 32'd0);
        chk("fwd_valid", fwd_valid, wr);
        chk("fwd_rd", fwd_rd, m_valid ? m_rd : 5'd0);
        chk("fwd_data", fwd_data, m_valid ? word : 32'd0);
        chk("instret", instret, m_instret);
        chk("instret4", instret4, m_instret[3:0]);
        if (exp_we) exp_q.push_back({m_rd, word});
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rf_write_unexpected", {rf_waddr, rf_wdata}, 37'd0);
            end else begin
                got = exp_q.pop_front();
                chk("rf_write", {rf_waddr, rf_wdata}, got);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] r,
                         input logic w, input logic ld, input logic [2:0] f3);
        mem_valid = v;
        ALU_result = alu;
        rd = r;
        reg_w_ctrl_in = w;
        MemToReg = ld;
        funct3 = f3;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] exp_lb;
        logic [31:0] exp_lhu;
`ifdef WB_SUBWORD_LOAD_EN
        exp_lb = 32'hFFFF_FFDE;
        exp_lhu = 32'h0000_DEAD;
`else
        exp_lb = 32'hDEAD_BEEF;
        exp_lhu = 32'hDEAD_BEEF;
`endif
        // Reset, with stall held to show mem_wb_ready is purely combinational
        reset = 1'b0;
        wb_stall = 1'b1;
        repeat (3) tick();
        settle();
        chk("rst_ready", mem_wb_ready, 1'b0);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_instret", instret, 32'd0);
        wb_stall = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // ALU op to rd=5
        drive(1'b1, 32'h0000_1234, 5'd5, 1'b1, 1'b0, 3'd0);
        tick();
        idle();
        settle();
        chk("alu_we", rf_we, 1'b1);
        chk("alu_waddr", rf_waddr, 5'd5);
        chk("alu_wdata", rf_wdata, 32'h1234);
        chk("alu_instret_before", instret, 32'd0);
        tick();
        chk("alu_instret_after", instret, 32'd1);

        // lb rd=7 at addr_lo=3, then lhu rd=8 at addr_lo=2 back to back
        drive(1'b1, 32'h0000_1003, 5'd7, 1'b1, 1'b1, 3'b000);
        tick();
        drive(1'b1, 32'h0000_2002, 5'd8, 1'b1, 1'b1, 3'b101);
        read_data = 32'hDEAD_BEEF;
        settle();
        chk("lb_wdata", rf_wdata, exp_lb);
        tick();
        settle();
        chk("lhu_wdata", rf_wdata, exp_lhu);

        // lw rd=9, stalled for 3 cycles while memory output drops to 0
        drive(1'b1, 32'h0000_3000, 5'd9, 1'b1, 1'b1, 3'b010);
        tick();
        idle();
        wb_stall = 1'b1;
        read_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_we", rf_we, 1'b0);
            chk("stall_fwd_valid", fwd_valid, 1'b1);
            chk("stall_fwd_data", fwd_data, 32'hDEAD_BEEF);
            tick();
            read_data = 32'h0;
        end
        wb_stall = 1'b0;
        settle();
        chk("release_we", rf_we, 1'b1);
        chk("release_wdata", rf_wdata, 32'hDEAD_BEEF);
        chk("release_instret", instret, 32'd3);
        tick();
        chk("release_instret_after", instret, 32'd4);

        // Write to x0: no RF write, still retires
        drive(1'b1, 32'h0000_0055, 5'd0, 1'b1, 1'b0, 3'd0);
        tick();
        idle();
        settle();
        chk("x0_we", rf_we, 1'b0);
        chk("x0_fwd_valid", fwd_valid, 1'b0);
        tick();
        chk("x0_instret", instret, 32'd5);

        // Stall + flush together on a valid load
        drive(1'b1, 32'h0000_4000, 5'd3, 1'b1, 1'b1, 3'b010);
        tick();
        idle();
        wb_stall = 1'b1;
        wb_flush = 1'b1;
        read_data = 32'h1234_5678;
        tick();
        wb_stall = 1'b0;
        wb_flush = 1'b0;
        settle();
        chk("flush_fwd_valid", fwd_valid, 1'b0);
        chk("flush_we", rf_we, 1'b0);
        chk("flush_instret", instret, 32'd5);

        // Reset in the middle of a stalled load
        drive(1'b1, 32'h0000_5000, 5'd4, 1'b1, 1'b1, 3'b010);
        tick();
        idle();
        wb_stall = 1'b1;
        read_data = 32'hCAFE_0001;
        tick();
        read_data = 32'h0;
        reset = 1'b0;
        settle();
        chk("midrst_fwd_valid", fwd_valid, 1'b0);
        chk("midrst_fwd_data", fwd_data, 32'd0);
        chk("midrst_waddr", rf_waddr, 5'd0);
        chk("midrst_instret", instret, 32'd0);
        tick();
        reset = 1'b1;
        wb_stall = 1'b0;
        tick();
        settle();
        chk("postrst_we", rf_we, 1'b0);

        // Counter wrap on the 4-bit instance: 16 retires -> 0
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  1'b0, 3'd0);
            tick();
        end
        idle();
        settle();
        chk("wrap_pre4", instret4, 4'd15);
        tick();
        chk("wrap_post4", instret4, 4'd0);
        chk("wrap_post32", instret, 32'd16);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) reset = 1'b0;
            else reset = 1'b1;
            drive(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)));
            wb_stall = ($urandom_range(0, 3) == 0);
            wb_flush = ($urandom_range(0, 7) == 0);
            read_data = $urandom;
            tick();
        end
        wb_stall = 1'b0;
        wb_flush = 1'b0;
        idle();
        repeat (2) tick();
        chk("exp_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
